// File: rtl/mem_stream_reader_if.sv
// Bus bundle between the stream reader and the memory it drives plus the
// downstream consumer. The reader owns the master side; the memory and the
// consumer together form the slave side.
interface mem_stream_reader_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
);
    // memory port: combinational read of mem_r_data from mem_addr
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_w_data;
    logic [DATA_W-1:0] mem_r_data;

    // valid/ready stream of read words
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output mem_addr,
        output mem_wr_en,
        output mem_w_data,
        input  mem_r_data,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_wr_en,
        input  mem_w_data,
        output mem_r_data,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/mem_stream_reader.sv
// Burst initiator for a single-port memory: sweeps len words from base_addr,
// either streaming the read words out on a valid/ready port or writing a fill
// value to every address. One burst at a time; all outputs registered.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; start/mode/base/len/fill sampled here
//   RD    | reading: capture word into out_data, hold until accepted
//   WR    | clearing: one write of fill per cycle
//   FIN   | burst complete; done pulses for this single cycle
module mem_stream_reader #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clr_mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    mem_stream_reader_if.master bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    localparam logic [ADDR_W:0] REM_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] REM_ZERO = '0;

    state_t            state_q, state_d;
    // mem_addr doubles as the sweep pointer; it wraps naturally at 2**ADDR_W
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic [DATA_W-1:0] mem_w_data_q, mem_w_data_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    // words still to be written (WR) or still to be captured (RD)
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              capture;

    // next-state and next-output logic for the burst FSM
    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_wr_en_d  = mem_wr_en_q;
        mem_w_data_d = mem_w_data_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        remaining_d  = remaining_q;
        capture      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mem_addr_d   = base_addr;
                    remaining_d  = len;
                    mem_w_data_d = fill_data;
                    if (len == REM_ZERO) begin
                        state_d = FIN;
                    end else if (clr_mode) begin
                        // first write lands on the very next edge
                        state_d     = WR;
                        mem_wr_en_d = 1'b1;
                    end else begin
                        state_d = RD;
                    end
                end
            end

            WR: begin
                mem_addr_d  = mem_addr_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
                if (remaining_q == REM_ONE) begin
                    state_d     = FIN;
                    mem_wr_en_d = 1'b0;
                end
            end

            RD: begin
                capture = (remaining_q != REM_ZERO) &&
                          (!out_valid_q || bus.out_ready);
                if (capture) begin
                    out_data_d  = bus.mem_r_data;
                    out_valid_d = 1'b1;
                    mem_addr_d  = mem_addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                end else if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    // nothing left to capture, so this was the final word
                    if (remaining_q == REM_ZERO) begin
                        state_d = FIN;
                    end
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    // state and registered outputs; reset abandons any burst in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            mem_wr_en_q  <= 1'b0;
            mem_w_data_q <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            remaining_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_wr_en_q  <= mem_wr_en_d;
            mem_w_data_q <= mem_w_data_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            remaining_q  <= remaining_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wr_en  = mem_wr_en_q;
    assign bus.mem_w_data = mem_w_data_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader: stimulus pushes expected stream
// words and memory writes into queues; a negedge monitor pops and compares
// whenever the DUT hands over a word or issues a write.
module tb_mem_stream_reader;
    localparam int DATA_W = 4;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              clr_mode;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] fill_data;
    logic              busy;
    logic              done;

    mem_stream_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_stream_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .clr_mode  (clr_mode),
        .base_addr (base_addr),
        .len       (len),
        .fill_data (fill_data),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        tests++;
        failed++;
        $display("FAIL %s: got %0h expected none", name, act);
    endtask

    // memory model, combinational read
    logic [DATA_W-1:0] mem [DEPTH];
    int                wr_cnt [DEPTH];
    logic              init_mem;
    logic              clr_cnt;

    assign bus.mem_r_data = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i]    <= DATA_W'(i);
                wr_cnt[i] <= 0;
            end
        end else begin
            if (clr_cnt) begin
                for (int i = 0; i < DEPTH; i++) wr_cnt[i] <= 0;
            end
            if (bus.mem_wr_en) begin
                mem[bus.mem_addr]    <= bus.mem_w_data;
                wr_cnt[bus.mem_addr] <= wr_cnt[bus.mem_addr] + 1;
            end
        end
    end

    // downstream ready follows a repeating pattern
    logic [7:0] ready_pat = 8'hFF;
    int         plen      = 1;
    int         cyc       = 0;
    logic       rdy       = 1'b1;
    assign bus.out_ready = rdy;

    always @(posedge clk) begin
        #1;
        rdy = ready_pat[cyc % plen];
        cyc++;
    end

    // scoreboard queues
    logic [DATA_W-1:0]        exp_rd [$];
    logic [ADDR_W+DATA_W-1:0] exp_wr [$];

    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [ADDR_W-1:0] prev_addr;

    // monitor: handshakes, writes, stall stability, output exclusivity
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_data", 32'(bus.out_data), 32'(prev_data));
                check("stall_addr", 32'(bus.mem_addr), 32'(prev_addr));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_rd.size() == 0) flag("unexpected_word", 32'(bus.out_data));
                else check("rd_word", 32'(bus.out_data), 32'(exp_rd.pop_front()));
            end
            if (bus.mem_wr_en) begin
                if (exp_wr.size() == 0) flag("unexpected_write", 32'({bus.mem_addr, bus.mem_w_data}));
                else check("wr_addr_data", 32'({bus.mem_addr, bus.mem_w_data}), 32'(exp_wr.pop_front()));
            end
            if (bus.out_valid && (bus.mem_wr_en || !busy))
                flag("valid_outside_rd", 32'({bus.mem_wr_en, busy}));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_addr  = bus.mem_addr;
        end
    end

    // called at a negedge; returns at the following negedge
    task automatic do_start(input logic mode, input logic [ADDR_W-1:0] b,
                            input logic [ADDR_W:0] l, input logic [DATA_W-1:0] f);
        clr_mode  = mode;
        base_addr = b;
        len       = l;
        fill_data = f;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // counts negedges until done; notes the first negedge with activity
    task automatic wait_burst(output int n, output int first);
        n     = 0;
        first = -1;
        while (!done && n < 200) begin
            if (first < 0 && (bus.out_valid || bus.mem_wr_en)) first = n;
            @(negedge clk);
            n++;
        end
        if (first < 0 && (bus.out_valid || bus.mem_wr_en)) first = n;
        check("done_seen", 32'(done), 32'd1);
        @(negedge clk);
        check("done_one_cycle", 32'({done, busy}), 32'd0);
    endtask

    int n_done, n_first, bad;

    initial begin
        reset = 1'b1; start = 1'b0; clr_mode = 1'b0;
        base_addr = '0; len = '0; fill_data = '0;
        init_mem = 1'b1; clr_cnt = 1'b0;
        repeat (3) @(negedge clk);
        init_mem = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);

        // reset in the middle of a stalled READ burst
        ready_pat = 8'h00; plen = 1;
        do_start(1'b0, 5'd5, 6'd8, 4'h0);
        repeat (3) @(negedge clk);
        check("t1_valid_pre", 32'(bus.out_valid), 32'd1);
        check("t1_data_pre", 32'(bus.out_data), 32'd5);
        check("t1_addr_pre", 32'(bus.mem_addr), 32'd6);
        reset = 1'b1;
        @(negedge clk);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_valid", 32'(bus.out_valid), 32'd0);
        check("t1_addr", 32'(bus.mem_addr), 32'd0);
        check("t1_data", 32'(bus.out_data), 32'd0);
        check("t1_wr_en", 32'(bus.mem_wr_en), 32'd0);
        #2 reset = 1'b0;
        ready_pat = 8'hFF;
        @(negedge clk);

        // READ 0..7 at full rate
        for (int k = 0; k < 8; k++) exp_rd.push_back(DATA_W'(k));
        do_start(1'b0, 5'd0, 6'd8, 4'h0);
        wait_burst(n_done, n_first);
        check("t3_first", 32'(n_first), 32'd1);
        check("t3_done_lat", 32'(n_done), 32'd9);

        // backpressure 1,0,0,1 repeating
        ready_pat = 8'b0000_1001; plen = 4;
        for (int k = 0; k < 4; k++) exp_rd.push_back(DATA_W'(k));
        do_start(1'b0, 5'd0, 6'd4, 4'h0);
        wait_burst(n_done, n_first);
        check("t4_all_words", 32'(exp_rd.size()), 32'd0);
        ready_pat = 8'hFF; plen = 1;
        @(negedge clk);

        // address wrap 30,31,0,1
        exp_rd.push_back(4'hE); exp_rd.push_back(4'hF);
        exp_rd.push_back(4'h0); exp_rd.push_back(4'h1);
        do_start(1'b0, 5'd30, 6'd4, 4'h0);
        wait_burst(n_done, n_first);
        check("t5_done_lat", 32'(n_done), 32'd5);

        // zero-length bursts in both modes
        do_start(1'b0, 5'd7, 6'd0, 4'h0);
        wait_burst(n_done, n_first);
        check("t5_len0_rd_lat", 32'(n_done), 32'd0);
        check("t5_len0_rd_act", 32'(n_first), 32'hFFFF_FFFF);
        do_start(1'b1, 5'd7, 6'd0, 4'h3);
        wait_burst(n_done, n_first);
        check("t5_len0_wr_lat", 32'(n_done), 32'd0);
        check("t5_len0_wr_act", 32'(n_first), 32'hFFFF_FFFF);

        // CLEAR 3..6 with A, then read back 3..7
        for (int k = 3; k < 7; k++) exp_wr.push_back({ADDR_W'(k), 4'hA});
        do_start(1'b1, 5'd3, 6'd4, 4'hA);
        wait_burst(n_done, n_first);
        check("t2_first", 32'(n_first), 32'd0);
        check("t2_done_lat", 32'(n_done), 32'd4);
        for (int k = 0; k < 4; k++) exp_rd.push_back(4'hA);
        exp_rd.push_back(4'h7);
        do_start(1'b0, 5'd3, 6'd5, 4'h0);
        wait_burst(n_done, n_first);
        check("t2_readback_lat", 32'(n_done), 32'd6);

        // full-depth CLEAR with a stray start while busy
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        for (int k = 0; k < DEPTH; k++) exp_wr.push_back({ADDR_W'((9 + k) % DEPTH), 4'h5});
        do_start(1'b1, 5'd9, 6'd32, 4'h5);
        repeat (3) @(negedge clk);
        do_start(1'b0, 5'd2, 6'd3, 4'h0);
        wait_burst(n_done, n_first);
        check("t6_done_lat", 32'(n_done), 32'd28);
        bad = 0;
        for (int k = 0; k < DEPTH; k++)
            if (wr_cnt[k] != 1 || mem[k] != 4'h5) bad++;
        check("t6_each_addr_once", 32'(bad), 32'd0);

        repeat (3) @(negedge clk);
        check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
